// File: rtl/ramen_pkg.sv
// Shared state encoding and sizing constants for the ramen timer run-control stage.
package ramen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 10000;
  localparam int unsigned ELAPSED_W      = 12;

  // Debounce window in clock cycles, never shorter than one cycle.
  function automatic int unsigned deb_cycles(input int unsigned clk_hz, input int unsigned ms);
    int unsigned c;
    c = (clk_hz * ms) / 1000;
    return (c == 0) ? 32'd1 : c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-flop synchronizer -> stability filter -> one-cycle press pulse.
module key_debounce
  import ramen_pkg::*;
#(
  parameter int unsigned DEB_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Level follows the synchronized key only after DEB_CYC consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level_d & ~r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/ramen_timer_ctrl.sv
// Start/pause/clear run control feeding the elapsed-time digit chain: second tick,
// chain clear, brew-target completion with blinking alarm, and overflow error.
module ramen_timer_ctrl
  import ramen_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TARGET_SEC  = 180,
  parameter int unsigned BLINK_HZ    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_start_n,
  input  logic                 key_clear_n,
  input  logic                 ovf_in,
  output logic                 sec_tick,
  output logic                 chain_clr,
  output logic [ELAPSED_W-1:0] elapsed_sec,
  output logic                 run_led,
  output logic                 pause_led,
  output logic                 alarm_led
);

  localparam int unsigned DEB_CYC  = deb_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned HALF     = (HALF_RAW == 0) ? 1 : HALF_RAW;
  localparam int unsigned PRESC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BLINK_W  = (HALF > 1) ? $clog2(HALF) : 1;

  state_t               r_state;
  logic [PRESC_W-1:0]   r_presc;
  logic [BLINK_W-1:0]   r_blink;
  logic [ELAPSED_W-1:0] r_elapsed;
  logic                 r_chain_clr;
  logic                 r_alarm;

  logic                 w_start;
  logic                 w_clear;
  logic                 w_tick;
  logic                 w_hit;
  logic [ELAPSED_W-1:0] w_elapsed_inc;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_start_n),
    .o_press (w_start)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_clear_n),
    .o_press (w_clear)
  );

  assign w_tick        = (r_state == RUN) && (r_presc == PRESC_W'(CLK_HZ - 1));
  assign w_elapsed_inc = r_elapsed + 1'b1;
  assign w_hit         = (w_elapsed_inc == ELAPSED_W'(TARGET_SEC));

  // Priority inside each state: ovf_in > clear press > tick > start press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_presc     <= '0;
      r_blink     <= '0;
      r_elapsed   <= '0;
      r_chain_clr <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_chain_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_clear) begin
            r_chain_clr <= 1'b1;
            r_elapsed   <= '0;
          end else if (w_start) begin
            r_state <= RUN;
            r_presc <= '0;
          end
        end
        RUN: begin
          if (ovf_in) begin
            r_state <= ERROR;
            r_alarm <= 1'b1;
          end else if (w_clear) begin
            r_state     <= IDLE;
            r_chain_clr <= 1'b1;
            r_elapsed   <= '0;
            r_presc     <= '0;
          end else if (w_tick) begin
            r_presc   <= '0;
            r_elapsed <= w_elapsed_inc;
            if (w_hit) begin
              r_state <= DONE;
              r_blink <= '0;
              r_alarm <= 1'b1;
            end else if (w_start) begin
              r_state <= PAUSE;
            end
          end else if (w_start) begin
            r_state <= PAUSE;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        PAUSE: begin
          if (w_clear) begin
            r_state     <= IDLE;
            r_chain_clr <= 1'b1;
            r_elapsed   <= '0;
            r_presc     <= '0;
          end else if (w_start) begin
            r_state <= RUN;
          end
        end
        DONE: begin
          if (w_clear || w_start) begin
            r_state     <= IDLE;
            r_chain_clr <= 1'b1;
            r_elapsed   <= '0;
            r_presc     <= '0;
            r_blink     <= '0;
            r_alarm     <= 1'b0;
          end else if (r_blink == BLINK_W'(HALF - 1)) begin
            r_blink <= '0;
            r_alarm <= ~r_alarm;
          end else begin
            r_blink <= r_blink + 1'b1;
          end
        end
        ERROR: begin
          if (w_clear) begin
            r_state     <= IDLE;
            r_chain_clr <= 1'b1;
            r_elapsed   <= '0;
            r_presc     <= '0;
            r_alarm     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sec_tick    = w_tick;
  assign chain_clr   = r_chain_clr;
  assign elapsed_sec = r_elapsed;
  assign run_led     = (r_state == RUN);
  assign pause_led   = (r_state == PAUSE);
  assign alarm_led   = r_alarm;

endmodule

// File: tb/tb_ramen_timer_ctrl.sv
// Bench for ramen_timer_ctrl: a table of {inputs, hold cycles, expected LEDs/elapsed}
// records plus a scoreboard of expected sec_tick/chain_clr pulse cycles.
module tb_ramen_timer_ctrl;

  localparam int unsigned CLK_HZ      = 100;
  localparam int unsigned DEBOUNCE_MS = 20;
  localparam int unsigned TARGET_SEC  = 3;
  localparam int unsigned BLINK_HZ    = 5;

  // Expected {run_led, pause_led, alarm_led}
  localparam logic [2:0] L_IDLE  = 3'b000;
  localparam logic [2:0] L_RUN   = 3'b100;
  localparam logic [2:0] L_PAUSE = 3'b010;
  localparam logic [2:0] L_ALM   = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_start_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic        ovf_in = 1'b0;
  logic        sec_tick;
  logic        chain_clr;
  logic [11:0] elapsed_sec;
  logic        run_led;
  logic        pause_led;
  logic        alarm_led;

  always #5 clk = ~clk;

  ramen_timer_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .TARGET_SEC  (TARGET_SEC),
    .BLINK_HZ    (BLINK_HZ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .ovf_in      (ovf_in),
    .sec_tick    (sec_tick),
    .chain_clr   (chain_clr),
    .elapsed_sec (elapsed_sec),
    .run_led     (run_led),
    .pause_led   (pause_led),
    .alarm_led   (alarm_led)
  );

  typedef struct {
    logic       s_n;
    logic       c_n;
    logic       ovf;
    int         n;
    logic [2:0] leds;
    int         el;
    int         tick_ofs;
    int         clr_ofs;
  } vec_t;

  typedef struct {
    bit is_clr;
    int cyc;
  } evt_t;

  vec_t vecs[$];
  evt_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic observe(input bit is_clr);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pulse at cycle %0d: got %s, expected none", cyc,
               is_clr ? "chain_clr" : "sec_tick");
    end else begin
      e = exp_q.pop_front();
      check("pulse_kind", int'(is_clr), int'(e.is_clr));
      if (is_clr) check("chain_clr_cycle", cyc, e.cyc);
      else        check("sec_tick_cycle", cyc, e.cyc);
    end
  endtask

  // One clock: sample #1 after the edge, match pulses against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sec_tick)  observe(1'b0);
    if (chain_clr) observe(1'b1);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missed_pulse at cycle %0d: got no %s, expected one at cycle %0d", cyc,
               exp_q[0].is_clr ? "chain_clr" : "sec_tick", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic apply(input vec_t v);
    evt_t e;
    key_start_n = v.s_n;
    key_clear_n = v.c_n;
    ovf_in      = v.ovf;
    if (v.tick_ofs >= 0) begin
      e.is_clr = 1'b0;
      e.cyc    = cyc + v.tick_ofs;
      exp_q.push_back(e);
    end
    if (v.clr_ofs >= 0) begin
      e.is_clr = 1'b1;
      e.cyc    = cyc + v.clr_ofs;
      exp_q.push_back(e);
    end
    repeat (v.n) step();
    check("leds", int'({run_led, pause_led, alarm_led}), int'(v.leds));
    check("elapsed_sec", int'(elapsed_sec), v.el);
  endtask

  function automatic void add(input logic s_n, input logic c_n, input logic o, input int n,
                              input logic [2:0] leds, input int el, input int tick_ofs,
                              input int clr_ofs);
    vec_t v;
    v.s_n = s_n; v.c_n = c_n; v.ovf = o; v.n = n;
    v.leds = leds; v.el = el; v.tick_ofs = tick_ofs; v.clr_ofs = clr_ofs;
    vecs.push_back(v);
  endfunction

  function automatic void wait_v(input int n, input logic [2:0] leds, input int el,
                                 input int tick_ofs);
    add(1'b1, 1'b1, 1'b0, n, leds, el, tick_ofs, -1);
  endfunction

  // 3-cycle key press: pulse 5 cycles after the raw edge, state changes one cycle later.
  function automatic void press(input bit st, input bit cl, input logic [2:0] lb, input int eb,
                                input logic [2:0] la, input int ea, input bit clr);
    add(~st, ~cl, 1'b0, 3, lb, eb, -1, -1);
    add(1'b1, 1'b1, 1'b0, 2, lb, eb, -1, -1);
    add(1'b1, 1'b1, 1'b0, 1, la, ea, -1, clr ? 1 : -1);
  endfunction

  function automatic void run_to_done();
    wait_v(99, L_RUN, 0, 99);
    wait_v(1,  L_RUN, 1, -1);
    wait_v(99, L_RUN, 1, 99);
    wait_v(1,  L_RUN, 2, -1);
    wait_v(99, L_RUN, 2, 99);
    wait_v(1,  L_ALM, 3, -1);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;

    // IDLE: ovf ignored, 1-cycle glitches filtered, clear pulses the chain, clear beats start
    add(1'b1, 1'b1, 1'b1, 2, L_IDLE, 0, -1, -1);
    wait_v(2, L_IDLE, 0, -1);
    add(1'b0, 1'b1, 1'b0, 1, L_IDLE, 0, -1, -1);
    wait_v(4, L_IDLE, 0, -1);
    add(1'b0, 1'b1, 1'b0, 1, L_IDLE, 0, -1, -1);
    wait_v(6, L_IDLE, 0, -1);
    press(1'b0, 1'b1, L_IDLE, 0, L_IDLE, 0, 1'b1);
    wait_v(4, L_IDLE, 0, -1);
    press(1'b1, 1'b1, L_IDLE, 0, L_IDLE, 0, 1'b1);
    wait_v(4, L_IDLE, 0, -1);
    // Uninterrupted run to DONE, blink phases, start press leaves DONE
    press(1'b1, 1'b0, L_IDLE, 0, L_RUN, 0, 1'b0);
    run_to_done();
    wait_v(9, L_ALM, 3, -1);
    wait_v(1, L_IDLE, 3, -1);
    wait_v(9, L_IDLE, 3, -1);
    wait_v(1, L_ALM, 3, -1);
    press(1'b1, 1'b0, L_ALM, 3, L_IDLE, 0, 1'b1);
    wait_v(4, L_IDLE, 0, -1);
    // Pause at RUN cycle 150, resume 500 cycles later
    press(1'b1, 1'b0, L_IDLE, 0, L_RUN, 0, 1'b0);
    wait_v(99, L_RUN, 0, 99);
    wait_v(1,  L_RUN, 1, -1);
    wait_v(45, L_RUN, 1, -1);
    press(1'b1, 1'b0, L_RUN, 1, L_PAUSE, 1, 1'b0);
    wait_v(494, L_PAUSE, 1, -1);
    press(1'b1, 1'b0, L_PAUSE, 1, L_RUN, 1, 1'b0);
    wait_v(49, L_RUN, 1, 49);
    wait_v(1,  L_RUN, 2, -1);
    // Clear from RUN at elapsed 2
    wait_v(20, L_RUN, 2, -1);
    press(1'b0, 1'b1, L_RUN, 2, L_IDLE, 0, 1'b1);
    wait_v(150, L_IDLE, 0, -1);
    // Overflow in RUN, start ignored in ERROR, clear exits
    press(1'b1, 1'b0, L_IDLE, 0, L_RUN, 0, 1'b0);
    wait_v(10, L_RUN, 0, -1);
    add(1'b1, 1'b1, 1'b1, 1, L_ALM, 0, -1, -1);
    wait_v(3, L_ALM, 0, -1);
    press(1'b1, 1'b0, L_ALM, 0, L_ALM, 0, 1'b0);
    wait_v(30, L_ALM, 0, -1);
    press(1'b0, 1'b1, L_ALM, 0, L_IDLE, 0, 1'b1);
    wait_v(4, L_IDLE, 0, -1);
    // Into DONE again, stop mid-blink for the async reset
    press(1'b1, 1'b0, L_IDLE, 0, L_RUN, 0, 1'b0);
    run_to_done();
    wait_v(5, L_ALM, 3, -1);

    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", int'({run_led, pause_led, alarm_led}), int'(L_IDLE));
    check("rst_elapsed", int'(elapsed_sec), 0);
    check("rst_sec_tick", int'(sec_tick), 0);
    check("rst_chain_clr", int'(chain_clr), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_leds", int'({run_led, pause_led, alarm_led}), int'(L_IDLE));
    check("async_rst_elapsed", int'(elapsed_sec), 0);
    check("async_rst_sec_tick", int'(sec_tick), 0);
    check("async_rst_chain_clr", int'(chain_clr), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("post_rst_leds", int'({run_led, pause_led, alarm_led}), int'(L_IDLE));
    check("post_rst_elapsed", int'(elapsed_sec), 0);
    check("sb_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
